seq_shift_add_mul: RTL



---
 rtl/seq_shift_add_mul_pkg.sv | 19 +
 rtl/seq_shift_add_mul_adder.sv | 12 +
 rtl/seq_shift_add_mul.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seq_shift_add_mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier and
// other consumers of the 32-bit combinational adder.
package seq_shift_add_mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Carry-out of an unsigned add, recovered from the operand and sum MSBs.
  function automatic logic carry_out(input logic a_msb, input logic b_msb, input logic sum_msb);
    return (a_msb & b_msb) | ((a_msb ^ b_msb) & ~sum_msb);
  endfunction

endpackage

// File: rtl/seq_shift_add_mul_adder.sv
// The team's 32-bit combinational adder; carry-out is derived by the consumer.
module seq_shift_add_mul_adder
  import seq_shift_add_mul_pkg::*;
(
  input  logic [MUL_WIDTH-1:0] a,
  input  logic [MUL_WIDTH-1:0] b,
  output logic [MUL_WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/seq_shift_add_mul.sv
// Iterative unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier, one add per clock.
// Optional early termination on exhausted multiplier bits: SEQ_MUL_EARLY_TERM_EN.
module seq_shift_add_mul
  import seq_shift_add_mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_mcand,
  input  logic [WIDTH-1:0]   in_mplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy
);

  if (WIDTH != MUL_WIDTH) begin : g_bad_width
    $error("seq_shift_add_mul: WIDTH must equal the adder width");
  end
  if ((2 ** CNT_W) <= WIDTH) begin : g_bad_cnt_w
    $error("seq_shift_add_mul: 2**CNT_W must exceed WIDTH");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;

  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [WIDTH-1:0] hi_n;
  logic             c_n;

  seq_shift_add_mul_adder u_adder (
    .a   (hi_q),
    .b   (mcand_q),
    .sum (sum)
  );

  assign carry = carry_out(hi_q[WIDTH-1], mcand_q[WIDTH-1], sum[WIDTH-1]);

`ifdef SEQ_MUL_EARLY_TERM_EN
  localparam logic [CNT_W:0] WIDTH_V = (CNT_W+1)'(WIDTH);

  // Low WIDTH-cnt bits of lo still hold unconsumed multiplier bits.
  logic [WIDTH-1:0]   rem_mask;
  logic [CNT_W:0]     shamt;
  logic [2*WIDTH-1:0] prod_sh;

  assign rem_mask = {WIDTH{1'b1}} >> cnt_q;
  assign shamt    = WIDTH_V - {1'b0, cnt_q};
  assign prod_sh  = {hi_q, lo_q} >> shamt;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    hi_n      = hi_q;
    c_n       = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mcand_d = in_mcand;
          lo_d    = in_mplier;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (lo_q[0]) begin
          c_n  = carry;
          hi_n = sum;
        end
        // 65-bit right shift of {carry, hi_n, lo}
        hi_d  = {c_n, hi_n[WIDTH-1:1]};
        lo_d  = {hi_n[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
`ifdef SEQ_MUL_EARLY_TERM_EN
        if ((lo_q & rem_mask) == '0) begin
          {hi_d, lo_d} = prod_sh;
          state_d      = DONE;
        end
`endif
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
    end
  end

  assign out_product = {hi_q, lo_q};

endmodule
